sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 137 +++++++++++++
 tb/tb_sram_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of an asynchronous SRAM: a channel scanner with priority
// and a host CPU that is forced through after CPU_MAX_WAIT consecutive lost arbitrations.
module sram_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 8,
    parameter int STROBE_CYC   = 2,
    parameter int CPU_MAX_WAIT = 4,
    localparam int SW          = $clog2(CPU_MAX_WAIT + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SCAN_REQ,
    input  logic              SCAN_WE,
    input  logic [ADDR_W-1:0] SCAN_ADDR,
    input  logic [DATA_W-1:0] SCAN_WDATA,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic              SCAN_ACK,
    output logic              CPU_ACK,
    output logic [DATA_W-1:0] RDATA,
    output logic              BUSY,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] DATA,
    output logic              nOE,
    output logic              nWE,
    output logic [1:0]        dbg_state,
    output logic [SW-1:0]     dbg_starve
);

    localparam int CW = $clog2(STROBE_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t              state;
    logic [CW-1:0]       strobe_cnt;
    logic [SW-1:0]       starve;
    logic                grant_cpu_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                drive_q;

    // Handshake: a requester raises REQ with WE/ADDR/WDATA and holds them all stable
    // until its ACK pulse (the HOLD cycle); REQ is only looked at while IDLE, so a REQ
    // still high after ACK is simply a new request at the next IDLE.
    logic              cpu_forced;
    logic              grant_scan;
    logic              grant_any;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        cpu_forced = CPU_REQ && (starve == SW'(CPU_MAX_WAIT));
        grant_scan = SCAN_REQ && !cpu_forced;
        grant_any  = SCAN_REQ || CPU_REQ;
        sel_we     = grant_scan ? SCAN_WE    : CPU_WE;
        sel_addr   = grant_scan ? SCAN_ADDR  : CPU_ADDR;
        sel_wdata  = grant_scan ? SCAN_WDATA : CPU_WDATA;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            strobe_cnt  <= '0;
            starve      <= '0;
            grant_cpu_q <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            drive_q     <= 1'b0;
            ADDR        <= '0;
            RDATA       <= '0;
            nOE         <= 1'b1;
            nWE         <= 1'b1;
            SCAN_ACK    <= 1'b0;
            CPU_ACK     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state       <= SETUP;
                        grant_cpu_q <= !grant_scan;
                        we_q        <= sel_we;
                        ADDR        <= sel_addr;
                        if (sel_we) begin
                            wdata_q <= sel_wdata;
                            drive_q <= 1'b1;
                        end
                        if (!grant_scan) begin
                            starve <= '0;
                        end else if (CPU_REQ && starve != SW'(CPU_MAX_WAIT)) begin
                            starve <= starve + SW'(1);
                        end
                    end
                end
                SETUP: begin
                    state      <= STROBE;
                    strobe_cnt <= '0;
                    nOE        <= we_q;
                    nWE        <= !we_q;
                end
                STROBE: begin
                    if (strobe_cnt == CW'(STROBE_CYC - 1)) begin
                        // Read data is sampled while nOE is still low on this edge.
                        state <= HOLD;
                        nOE   <= 1'b1;
                        nWE   <= 1'b1;
                        if (!we_q) RDATA <= DATA;
                        CPU_ACK  <= grant_cpu_q;
                        SCAN_ACK <= !grant_cpu_q;
                    end else begin
                        strobe_cnt <= strobe_cnt + CW'(1);
                    end
                end
                HOLD: begin
                    state    <= IDLE;
                    drive_q  <= 1'b0;
                    SCAN_ACK <= 1'b0;
                    CPU_ACK  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign DATA       = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign BUSY       = (state != IDLE);
    assign dbg_state  = state;
    assign dbg_starve = starve;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios then randomized request batches, checked
// cycle by cycle against a queue-based reference model of the arbitration rules.
module tb_sram_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int S      = 2;
    localparam int MAXW   = 4;
    localparam int SW     = $clog2(MAXW + 1);
    localparam logic [1:0] IDLE_CODE = 2'd0;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              SCAN_REQ = 1'b0, SCAN_WE = 1'b0;
    logic [ADDR_W-1:0] SCAN_ADDR = '0;
    logic [DATA_W-1:0] SCAN_WDATA = '0;
    logic              CPU_REQ = 1'b0, CPU_WE = 1'b0;
    logic [ADDR_W-1:0] CPU_ADDR = '0;
    logic [DATA_W-1:0] CPU_WDATA = '0;
    logic              SCAN_ACK, CPU_ACK, BUSY, nOE, nWE;
    logic [DATA_W-1:0] RDATA;
    logic [ADDR_W-1:0] ADDR;
    logic [1:0]        dbg_state;
    logic [SW-1:0]     dbg_starve;
    tri1  [DATA_W-1:0] sram_data;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STROBE_CYC(S), .CPU_MAX_WAIT(MAXW)) dut (
        .CLK(CLK), .RESET(RESET),
        .SCAN_REQ(SCAN_REQ), .SCAN_WE(SCAN_WE), .SCAN_ADDR(SCAN_ADDR), .SCAN_WDATA(SCAN_WDATA),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .SCAN_ACK(SCAN_ACK), .CPU_ACK(CPU_ACK), .RDATA(RDATA), .BUSY(BUSY), .ADDR(ADDR),
        .DATA(sram_data), .nOE(nOE), .nWE(nWE), .dbg_state(dbg_state), .dbg_starve(dbg_starve)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    // SRAM device model: drives the bus while nOE is low, stores while nWE is low.
    logic [DATA_W-1:0] sram_mem [0:(1<<ADDR_W)-1];
    assign sram_data = (!nOE) ? sram_mem[ADDR] : {DATA_W{1'bz}};
    always @(negedge CLK) if (!nWE) sram_mem[ADDR] <= sram_data;

    // reference model and scoreboard
    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } op_t;

    op_t               scan_q[$];
    op_t               cpu_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    int                model_wait = 0;
    logic [DATA_W-1:0] model_rdata = '0;
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // continuous properties
    logic              mon_busy = 1'b0;
    logic [ADDR_W-1:0] mon_addr = '0;
    always @(negedge CLK) begin
        chk("oe_we_exclusive", 32'(nOE | nWE), 32'd1);
        if (mon_busy && BUSY) chk("addr_stable", 32'(ADDR), 32'(mon_addr));
        mon_busy <= BUSY;
        mon_addr <= ADDR;
    end

    // driver
    task automatic present();
        SCAN_REQ = (scan_q.size() > 0);
        if (SCAN_REQ) begin
            SCAN_WE = scan_q[0].we; SCAN_ADDR = scan_q[0].addr; SCAN_WDATA = scan_q[0].wdata;
        end
        CPU_REQ = (cpu_q.size() > 0);
        if (CPU_REQ) begin
            CPU_WE = cpu_q[0].we; CPU_ADDR = cpu_q[0].addr; CPU_WDATA = cpu_q[0].wdata;
        end
    endtask

    function automatic op_t mk(input bit we, input int addr, input int wdata);
        op_t o;
        o.we = we; o.addr = ADDR_W'(addr); o.wdata = DATA_W'(wdata);
        return o;
    endfunction

    // One access: requests are already presented; the ACK is due 'lat' falling edges later.
    task automatic expect_grant(input int lat);
        bit  cpu_wins;
        bit  in_strobe;
        op_t op;
        int  setup_k;
        logic [DATA_W-1:0] new_rdata;
        if (scan_q.size() > 0 && cpu_q.size() > 0) cpu_wins = (model_wait >= MAXW);
        else cpu_wins = (cpu_q.size() > 0);
        op = cpu_wins ? cpu_q[0] : scan_q[0];
        if (cpu_wins) model_wait = 0;
        else if (cpu_q.size() > 0) model_wait++;
        if (!op.we) exp_q.push_back(ref_mem[op.addr]);
        setup_k = lat - S - 1;
        for (int k = 1; k <= lat; k++) begin
            @(negedge CLK);
            in_strobe = (k > setup_k) && (k < lat);
            chk("noe", 32'(nOE), 32'(!(!op.we && in_strobe)));
            chk("nwe", 32'(nWE), 32'(!(op.we && in_strobe)));
            chk("busy", 32'(BUSY), 32'(k >= setup_k));
            chk("scan_ack", 32'(SCAN_ACK), 32'(k == lat && !cpu_wins));
            chk("cpu_ack", 32'(CPU_ACK), 32'(k == lat && cpu_wins));
            if (k >= setup_k) chk("addr", 32'(ADDR), 32'(op.addr));
            if (op.we && k >= setup_k) chk("data_driven", 32'(sram_data), 32'(op.wdata));
            else if (!in_strobe) chk("data_released", 32'(sram_data), 32'({DATA_W{1'b1}}));
            if (k == lat) begin
                new_rdata = op.we ? model_rdata : exp_q.pop_front();
                chk("rdata_ack", 32'(RDATA), 32'(new_rdata));
                chk("starve", 32'(dbg_starve), 32'(model_wait));
                model_rdata = new_rdata;
            end else begin
                chk("rdata_hold", 32'(RDATA), 32'(model_rdata));
            end
        end
        if (op.we) ref_mem[op.addr] = op.wdata;
        if (cpu_wins) void'(cpu_q.pop_front());
        else void'(scan_q.pop_front());
        present();
    endtask

    task automatic run_queues();
        @(negedge CLK);
        chk("idle_busy", 32'(BUSY), 32'd0);
        chk("idle_acks", 32'({SCAN_ACK, CPU_ACK}), 32'd0);
        present();
        expect_grant(S + 2);
        while (scan_q.size() + cpu_q.size() > 0) expect_grant(S + 3);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_noe"}, 32'(nOE), 32'd1);
        chk({tag, "_nwe"}, 32'(nWE), 32'd1);
        chk({tag, "_data"}, 32'(sram_data), 32'({DATA_W{1'b1}}));
        chk({tag, "_addr"}, 32'(ADDR), 32'd0);
        chk({tag, "_rdata"}, 32'(RDATA), 32'd0);
        chk({tag, "_acks"}, 32'({SCAN_ACK, CPU_ACK}), 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_starve"}, 32'(dbg_starve), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE_CODE));
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            sram_mem[i] = DATA_W'(i) ^ 8'h96;
            ref_mem[i]  = DATA_W'(i) ^ 8'h96;
        end
        repeat (3) @(negedge CLK);
        check_reset_values("reset");
        RESET = 1'b0;

        // CPU write 0x003 <= 0x5A, then read it back
        cpu_q.push_back(mk(1, 'h003, 'h5A));
        run_queues();
        cpu_q.push_back(mk(0, 'h003, 0));
        run_queues();

        // simultaneous SCAN read and CPU read: SCAN first, CPU one period later
        scan_q.push_back(mk(0, 'h001, 0));
        cpu_q.push_back(mk(0, 'h003, 0));
        run_queues();

        // SCAN held across six accesses while CPU waits: forced CPU grant on the fifth
        for (int i = 0; i < 6; i++) scan_q.push_back(mk(0, 'h001 + i, 0));
        cpu_q.push_back(mk(0, 'h003, 0));
        run_queues();

        // reset during the second STROBE cycle of a write aborts it without ACK
        cpu_q.push_back(mk(1, 'h3F0, 'hC3));
        @(negedge CLK);
        present();
        repeat (3) @(negedge CLK);
        chk("pre_abort_nwe", 32'(nWE), 32'd0);
        RESET = 1'b1;
        #1;
        check_reset_values("abort");
        cpu_q.delete();
        present();
        model_wait  = 0;
        model_rdata = '0;
        @(negedge CLK);
        RESET = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            chk("abort_no_ack", 32'({SCAN_ACK, CPU_ACK}), 32'd0);
            chk("abort_idle", 32'(BUSY), 32'd0);
        end
        cpu_q.push_back(mk(0, 'h003, 0));
        run_queues();

        // randomized batches from both requesters
        for (int b = 0; b < 8; b++) begin
            int n_s, n_c;
            n_s = $urandom_range(0, 6);
            n_c = $urandom_range(0, 3);
            if (n_s + n_c == 0) n_c = 1;
            for (int i = 0; i < n_s; i++)
                scan_q.push_back(mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom));
            for (int i = 0; i < n_c; i++)
                cpu_q.push_back(mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom));
            run_queues();
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
